// File: rtl/text_cursor_engine.sv
// text_cursor_engine: renders decoded character/command bytes into text VRAM,
// tracking the cursor and a circular scroll base, with multi-cycle space fills.
module text_cursor_engine #(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 30,
    parameter int         COL_W      = 7,
    parameter int         ROW_W      = 5,
    parameter int         ADDR_W     = 12,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] CMD_HOME   = 8'h01,
    parameter logic [7:0] CMD_EOL    = 8'h05,
    parameter logic [7:0] CMD_SOL    = 8'h06,
    parameter logic [7:0] CMD_LINE   = 8'h07,
    parameter logic [7:0] CMD_CLS    = 8'h0C,
    parameter logic [7:0] CMD_UP     = 8'h11,
    parameter logic [7:0] CMD_DOWN   = 8'h12,
    parameter logic [7:0] CMD_LEFT   = 8'h13,
    parameter logic [7:0] CMD_RIGHT  = 8'h14
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              charInValid,
    input  logic [7:0]        charIn,
    output logic              vramWrEn,
    output logic [ADDR_W-1:0] vramAddr,
    output logic [7:0]        vramData,
    output logic [COL_W-1:0]  cursorCol,
    output logic [ROW_W-1:0]  cursorRow,
    output logic [ROW_W-1:0]  scrollBase,
    output logic              busy,
    output logic              overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W:0]    PTR_ONE  = (PTR_W+1)'(1);
    localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ROW_W:0]    ROWS_X   = (ROW_W+1)'(ROWS);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] CELLS_A  = ADDR_W'(COLS * ROWS);
    localparam logic [7:0]        SPACE    = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SCROLL
    } state_t;

    state_t state_q, state_d;

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ROW_W-1:0]  base_q, base_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
    logic              cls_q, cls_d;
    logic              ovf_q;

    logic [7:0]        fifo_q [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
    logic              empty, full, pop, push_ok;
    logic [7:0]        head;

    logic              start_fill;
    logic [ADDR_W-1:0] fs_addr, fs_cnt;

    logic [ROW_W:0]    row_sum;
    logic [ROW_W-1:0]  phys_row;
    logic [ADDR_W-1:0] row_start, cur_addr, scroll_start;
    logic [ROW_W-1:0]  base_next;
    logic              printable;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push_ok = charInValid && (!full || pop);
    assign head    = fifo_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (charInValid && !push_ok)
                ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && push_ok)
            fifo_q[wr_ptr_q[PTR_W-1:0]] <= charIn;
    end

    // Logical rows map onto physical rows through the circular scroll base.
    assign row_sum      = {1'b0, row_q} + {1'b0, base_q};
    assign phys_row     = (row_sum >= ROWS_X) ? ROW_W'(row_sum - ROWS_X)
                                              : ROW_W'(row_sum);
    assign row_start    = ADDR_W'(phys_row) * COLS_A;
    assign cur_addr     = row_start + ADDR_W'(col_q);
    assign base_next    = (base_q == LAST_ROW) ? '0 : base_q + ROW_ONE;
    assign scroll_start = ADDR_W'(base_q) * COLS_A;
    assign printable    = (head[6:0] >= 7'h20) && (head[6:0] != 7'h7F);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        base_d      = base_q;
        wr_en_d     = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        busy_d      = 1'b0;
        fill_addr_d = fill_addr_q;
        fill_cnt_d  = fill_cnt_q;
        cls_d       = cls_q;
        pop         = 1'b0;
        start_fill  = 1'b0;
        fs_addr     = '0;
        fs_cnt      = '0;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head == 8'h0D) begin
                        col_d = '0;
                    end else if (head == 8'h0A) begin
                        if (row_q != LAST_ROW) begin
                            row_d = row_q + ROW_ONE;
                        end else begin
                            base_d     = base_next;
                            start_fill = 1'b1;
                            fs_addr    = scroll_start;
                            fs_cnt     = COLS_A;
                        end
                    end else if (head == 8'h08) begin
                        if (col_q != '0)
                            col_d = col_q - COL_ONE;
                    end else if (head == CMD_UP) begin
                        if (row_q != '0)
                            row_d = row_q - ROW_ONE;
                    end else if (head == CMD_DOWN) begin
                        if (row_q != LAST_ROW)
                            row_d = row_q + ROW_ONE;
                    end else if (head == CMD_LEFT) begin
                        if (col_q != '0)
                            col_d = col_q - COL_ONE;
                    end else if (head == CMD_RIGHT) begin
                        if (col_q != LAST_COL)
                            col_d = col_q + COL_ONE;
                    end else if (head == CMD_HOME) begin
                        col_d = '0;
                    end else if (head == CMD_CLS) begin
                        start_fill = 1'b1;
                        fs_addr    = '0;
                        fs_cnt     = CELLS_A;
                        cls_d      = 1'b1;
                    end else if (head == CMD_EOL) begin
                        start_fill = 1'b1;
                        fs_addr    = cur_addr;
                        fs_cnt     = COLS_A - ADDR_W'(col_q);
                    end else if (head == CMD_SOL) begin
                        start_fill = 1'b1;
                        fs_addr    = row_start;
                        fs_cnt     = ADDR_W'(col_q) + ADDR_ONE;
                    end else if (head == CMD_LINE) begin
                        start_fill = 1'b1;
                        fs_addr    = row_start;
                        fs_cnt     = COLS_A;
                    end else if (printable) begin
                        wr_en_d = 1'b1;
                        addr_d  = cur_addr;
                        data_d  = head;
                        if (col_q != LAST_COL) begin
                            col_d = col_q + COL_ONE;
                        end else begin
                            col_d = '0;
                            if (row_q != LAST_ROW)
                                row_d = row_q + ROW_ONE;
                            else
                                state_d = SCROLL;
                        end
                    end
                end
            end
            SCROLL: begin
                base_d     = base_next;
                start_fill = 1'b1;
                fs_addr    = scroll_start;
                fs_cnt     = COLS_A;
            end
            FILL: begin
                wr_en_d     = 1'b1;
                addr_d      = fill_addr_q;
                data_d      = SPACE;
                busy_d      = 1'b1;
                fill_addr_d = fill_addr_q + ADDR_ONE;
                fill_cnt_d  = fill_cnt_q - ADDR_ONE;
                if (fill_cnt_q == ADDR_ONE) begin
                    state_d = IDLE;
                    if (cls_q) begin
                        col_d  = '0;
                        row_d  = '0;
                        base_d = '0;
                        cls_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The first fill write goes out on the same edge the fill is started.
        if (start_fill) begin
            wr_en_d     = 1'b1;
            addr_d      = fs_addr;
            data_d      = SPACE;
            busy_d      = 1'b1;
            fill_addr_d = fs_addr + ADDR_ONE;
            fill_cnt_d  = fs_cnt - ADDR_ONE;
            state_d     = (fs_cnt == ADDR_ONE) ? IDLE : FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            base_q      <= '0;
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            fill_addr_q <= '0;
            fill_cnt_q  <= '0;
            cls_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            base_q      <= base_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            fill_addr_q <= fill_addr_d;
            fill_cnt_q  <= fill_cnt_d;
            cls_q       <= cls_d;
        end
    end

    assign vramWrEn   = wr_en_q;
    assign vramAddr   = addr_q;
    assign vramData   = data_q;
    assign cursorCol  = col_q;
    assign cursorRow  = row_q;
    assign scrollBase = base_q;
    assign busy       = busy_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_text_cursor_engine.sv
// Bench for text_cursor_engine: directed scenarios plus random byte stream
// checked against a screen-level reference model.
module tb_text_cursor_engine;

    localparam int COLS = 80;
    localparam int ROWS = 30;

    localparam logic [7:0] C_HOME  = 8'h01;
    localparam logic [7:0] C_EOL   = 8'h05;
    localparam logic [7:0] C_SOL   = 8'h06;
    localparam logic [7:0] C_LINE  = 8'h07;
    localparam logic [7:0] C_CLS   = 8'h0C;
    localparam logic [7:0] C_UP    = 8'h11;
    localparam logic [7:0] C_DOWN  = 8'h12;
    localparam logic [7:0] C_LEFT  = 8'h13;
    localparam logic [7:0] C_RIGHT = 8'h14;

    typedef struct {
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        charInValid = 1'b0;
    logic [7:0]  charIn = 8'h00;
    logic        vramWrEn;
    logic [11:0] vramAddr;
    logic [7:0]  vramData;
    logic [6:0]  cursorCol;
    logic [4:0]  cursorRow;
    logic [4:0]  scrollBase;
    logic        busy;
    logic        overflow;

    int total = 0;
    int bad = 0;
    int wr_count = 0;
    wr_t wlog[$];
    logic [7:0] cap [4096];
    logic [7:0] m_vram [4096];
    int m_col, m_row, m_base;
    logic [7:0] junk [4] = '{8'h00, 8'h7F, 8'hFF, 8'h8D};

    text_cursor_engine dut (
        .clk        (clk),
        .resetn     (resetn),
        .charInValid(charInValid),
        .charIn     (charIn),
        .vramWrEn   (vramWrEn),
        .vramAddr   (vramAddr),
        .vramData   (vramData),
        .cursorCol  (cursorCol),
        .cursorRow  (cursorRow),
        .scrollBase (scrollBase),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vramWrEn === 1'b1) begin
            cap[vramAddr] = vramData;
            wlog.push_back('{vramAddr, vramData});
            wr_count++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int phys(input int r);
        return (r + m_base) % ROWS;
    endfunction

    task automatic m_lf();
        if (m_row < ROWS - 1) begin
            m_row++;
        end else begin
            m_base = (m_base + 1) % ROWS;
            for (int c = 0; c < COLS; c++)
                m_vram[phys(ROWS - 1) * COLS + c] = 8'h20;
        end
    endtask

    task automatic m_apply(input logic [7:0] b);
        int p;
        p = phys(m_row) * COLS;
        if (b == 8'h0D) m_col = 0;
        else if (b == 8'h0A) m_lf();
        else if (b == 8'h08) begin if (m_col > 0) m_col--; end
        else if (b == C_UP) begin if (m_row > 0) m_row--; end
        else if (b == C_DOWN) begin if (m_row < ROWS - 1) m_row++; end
        else if (b == C_LEFT) begin if (m_col > 0) m_col--; end
        else if (b == C_RIGHT) begin if (m_col < COLS - 1) m_col++; end
        else if (b == C_HOME) m_col = 0;
        else if (b == C_CLS) begin
            for (int i = 0; i < COLS * ROWS; i++) m_vram[i] = 8'h20;
            m_col = 0; m_row = 0; m_base = 0;
        end
        else if (b == C_EOL) begin
            for (int c = m_col; c < COLS; c++) m_vram[p + c] = 8'h20;
        end
        else if (b == C_SOL) begin
            for (int c = 0; c <= m_col; c++) m_vram[p + c] = 8'h20;
        end
        else if (b == C_LINE) begin
            for (int c = 0; c < COLS; c++) m_vram[p + c] = 8'h20;
        end
        else if (b[6:0] >= 7'h20 && b[6:0] <= 7'h7E) begin
            m_vram[p + m_col] = b;
            if (m_col == COLS - 1) begin
                m_col = 0;
                m_lf();
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic push(input logic [7:0] b);
        charIn = b;
        charInValid = 1'b1;
        @(posedge clk);
        #1;
        charInValid = 1'b0;
        charIn = 8'h00;
    endtask

    task automatic wait_idle();
        int q;
        q = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6000 && q < 3; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && vramWrEn === 1'b0) q++;
            else q = 0;
        end
        if (q < 3) chk("idle_timeout", q, 3);
    endtask

    task automatic send(input logic [7:0] b);
        push(b);
        m_apply(b);
        wait_idle();
    endtask

    task automatic chk_vram(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 4096; i++)
            if (cap[i] !== m_vram[i]) n++;
        chk(tag, n, 0);
    endtask

    task automatic chk_cursor(input string tag);
        chk({tag, "_col"}, cursorCol, m_col);
        chk({tag, "_row"}, cursorRow, m_row);
        chk({tag, "_base"}, scrollBase, m_base);
    endtask

    function automatic logic [7:0] rnd_print();
        logic [7:0] b;
        b = {1'($urandom_range(0, 1)), 7'($urandom_range(32, 126))};
        return b;
    endfunction

    initial begin
        int bc, cnt;
        bit seen, done;
        logic [7:0] b;
        int r;

        for (int i = 0; i < 4096; i++) begin
            cap[i] = 8'h00;
            m_vram[i] = 8'h00;
        end
        m_col = 0; m_row = 0; m_base = 0;

        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("rst_wren", vramWrEn, 0);
        chk("rst_addr", vramAddr, 0);
        chk("rst_data", vramData, 0);
        chk("rst_col", cursorCol, 0);
        chk("rst_row", cursorRow, 0);
        chk("rst_base", scrollBase, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);

        push(8'h41);
        m_apply(8'h41);
        @(negedge clk);
        chk("t1_wren_early", vramWrEn, 0);
        @(negedge clk);
        chk("t1_wren", vramWrEn, 1);
        chk("t1_addr", vramAddr, 0);
        chk("t1_data", vramData, 8'h41);
        chk("t1_col", cursorCol, 1);
        wait_idle();

        for (int i = 0; i < 78; i++) send(rnd_print());
        chk("t2_col79", cursorCol, 79);
        push(8'hC1);
        m_apply(8'hC1);
        @(negedge clk);
        @(negedge clk);
        chk("t2_wren", vramWrEn, 1);
        chk("t2_addr", vramAddr, 79);
        chk("t2_data", vramData, 8'hC1);
        wait_idle();
        chk("t2_row", cursorRow, 1);
        chk("t2_col", cursorCol, 0);
        chk("t2_base", scrollBase, 0);

        for (int i = 0; i < 28; i++) send(8'h0A);
        chk("t3_row29", cursorRow, 29);
        wlog.delete();
        push(8'h0A);
        m_apply(8'h0A);
        bc = 0; seen = 0; done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                bc++;
                seen = 1;
            end else if (seen) begin
                done = 1;
            end
        end
        chk("t3_busy_cycles", bc, 80);
        chk("t3_writes", wlog.size(), 80);
        chk("t3_first_addr", wlog[0].a, 0);
        chk("t3_last_addr", wlog[79].a, 79);
        chk("t3_last_data", wlog[79].d, 8'h20);
        wait_idle();
        chk_cursor("t3");
        chk_vram("t3_vram");

        wlog.delete();
        push(C_CLS);
        push(8'h78);
        push(8'h79);
        push(8'h7A);
        m_apply(C_CLS);
        m_apply(8'h78);
        m_apply(8'h79);
        m_apply(8'h7A);
        wait_idle();
        chk("t4_writes", wlog.size(), 2403);
        chk("t4_char_addr", wlog[2400].a, 0);
        chk("t4_char_data", wlog[2400].d, 8'h78);
        chk("t4_ovf", overflow, 0);
        chk_cursor("t4");
        chk_vram("t4_vram");

        push(C_CLS);
        for (int i = 0; i < 5; i++) push(8'h61 + 8'(i));
        m_apply(C_CLS);
        for (int i = 0; i < 4; i++) m_apply(8'h61 + 8'(i));
        wait_idle();
        chk("t5_ovf", overflow, 1);
        chk_cursor("t5");
        chk_vram("t5_vram");
        send(8'h71);
        chk("t5_ovf_sticky", overflow, 1);
        chk_vram("t5_vram2");

        push(C_CLS);
        repeat (100) @(negedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cnt = wr_count;
        chk("rst_mid_wren", vramWrEn, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ovf", overflow, 0);
        repeat (20) @(negedge clk);
        #1 resetn = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_mid_nowrites", wr_count, cnt);
        m_col = 0; m_row = 0; m_base = 0;
        chk_cursor("rst_mid");
        send(C_CLS);
        chk_vram("resync_vram");

        for (int i = 0; i < 58; i++) send(8'h0A);
        for (int i = 0; i < 26; i++) send(C_UP);
        send(8'h0D);
        for (int i = 0; i < 10; i++) send(rnd_print());
        chk("t6_pre_row", cursorRow, 3);
        chk("t6_pre_col", cursorCol, 10);
        chk("t6_pre_base", scrollBase, 29);
        wlog.delete();
        send(C_SOL);
        chk("t6_writes", wlog.size(), 11);
        chk("t6_first_addr", wlog[0].a, 160);
        chk("t6_last_addr", wlog[10].a, 170);
        chk_cursor("t6");
        chk_vram("t6_vram");

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55) b = rnd_print();
            else if (r < 62) b = 8'h0D;
            else if (r < 72) b = 8'h0A;
            else if (r < 77) b = 8'h08;
            else if (r < 92) begin
                case ($urandom_range(0, 4))
                    0: b = C_UP;
                    1: b = C_DOWN;
                    2: b = C_LEFT;
                    3: b = C_RIGHT;
                    default: b = C_HOME;
                endcase
            end else if (r < 97) begin
                case ($urandom_range(0, 2))
                    0: b = C_EOL;
                    1: b = C_SOL;
                    default: b = C_LINE;
                endcase
            end else begin
                b = junk[$urandom_range(0, 3)];
            end
            send(b);
            chk_cursor("rnd");
        end
        chk_vram("rnd_vram");
        chk("rnd_ovf", overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
